// File: rtl/arb_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the 8-way request/grant arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NREQ    = 8;   // number of requesters
  localparam int IDW     = 3;   // width of a requester index
  localparam int TIMEOUT = 15;  // default max hold cycles without done; 0 disables

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Purpose: combinational winner select, fixed priority (highest index) or round-robin after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the result is used.
// Ports:
//   i_req  - request vector, bit i = requester i
//   i_rr   - 1 selects round-robin search starting at i_ptr+1, 0 selects fixed priority
//   i_ptr  - index of the most recent grant (round-robin origin)
//   o_any  - at least one request is pending
//   o_id   - winning requester index (only meaningful when o_any=1)
module arb_prio_enc
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_rr,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_any,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0]    w_shift;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_enc;

  // Rotate so the first candidate in the search order lands at bit 0.
  // NREQ is a power of two, so the index arithmetic wraps for free.
  assign w_shift = i_rr ? i_ptr + 1'b1 : '0;
  assign w_dbl   = {i_req, i_req} >> w_shift;
  assign w_rot   = w_dbl[NREQ-1:0];

  // Round-robin takes the lowest set bit of the rotated vector; fixed
  // priority takes the highest set bit of the unrotated vector. In both
  // loops the last hit wins, which gives the required direction.
  always_comb begin
    w_enc = '0;
    if (i_rr) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (w_rot[i]) w_enc = IDW'(i);
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_rot[i]) w_enc = IDW'(i);
      end
    end
  end

  assign o_any = |i_req;
  assign o_id  = w_enc + w_shift;  // undo the rotation

endmodule

// File: rtl/rr_arbiter8.sv
// Purpose: 8-way request/grant/done arbiter, fixed or round-robin, with hold timeout.
// Latency: request sampled at an edge is granted after that edge; release takes one edge.
// Backpressure: owner holds the resource until done, req drop or timeout; one idle cycle between grants.
// Ports:
//   clk, rst     - clock (rising edge) and synchronous active-high reset
//   req[7:0]     - request vector; mode selects fixed (bit 7 highest) or round-robin
//   done         - resource finished with the current owner (ignored while idle)
//   gnt[7:0]     - registered one-hot grant; gnt_id its binary index; gnt_vld = |gnt
//   timeout_err  - one-cycle pulse when a grant is force-released by the hold timeout
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            mode,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld,
  output logic            timeout_err
);

  localparam int CNTW = $clog2(TIMEOUT_CYC + 2);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic            r_err;
  logic [IDW-1:0]  r_ptr;
  logic [CNTW-1:0] r_cnt;

  logic [NREQ-1:0] w_gnt_nxt;
  logic [IDW-1:0]  w_id_nxt;
  logic            w_err_nxt;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [CNTW-1:0] w_cnt_nxt;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [CNTW-1:0] w_cnt_inc;
  logic            w_own_req;
  logic            w_to;
  logic            w_release;

  arb_prio_enc u_enc (
    .i_req (req),
    .i_rr  (mode),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_id  (w_win)
  );

  // The counter reads 0 in the first grant cycle, so releasing when the
  // incremented value reaches the limit holds the grant exactly TIMEOUT_CYC cycles.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_own_req = req[r_gnt_id];
  assign w_to      = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNTW'(TIMEOUT_CYC));
  assign w_release = done || !w_own_req || w_to;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)     w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; req and mode only matter while idle.
  always_comb begin
    w_gnt_nxt = '0;
    w_id_nxt  = '0;
    w_err_nxt = 1'b0;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt = onehot(w_win);
          w_id_nxt  = w_win;
          w_ptr_nxt = w_win;
          w_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          // done or a dropped request take precedence over the timeout flag.
          w_err_nxt = w_to && !done && w_own_req;
          w_cnt_nxt = '0;
        end else begin
          w_gnt_nxt = r_gnt;
          w_id_nxt  = r_gnt_id;
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_err    <= 1'b0;
      r_ptr    <= '1;  // first round-robin search starts at requester 0
      r_cnt    <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_id_nxt;
      r_err    <= w_err_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_id      = r_gnt_id;
  assign gnt_vld     = |r_gnt;
  assign timeout_err = r_err;

endmodule
